// File: rtl/mod_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mod_ctrl_pkg
//  Description : Shared constants for the modulo-N counter controller:
//                FSM state encodings and default parameter values.
//  Revision    : 1.0  initial release
// ============================================================================
package mod_ctrl_pkg;

    // FSM state encodings (2 bits; encoding 3 is unreachable)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    // Default build parameters: 1 Hz count rate from a 50 MHz clock
    localparam int DEF_MODULUS  = 13;
    localparam int DEF_CNT_W    = 4;
    localparam int DEF_TICK_DIV = 50000000;
    localparam int DEF_DIV_W    = 26;

endpackage : mod_ctrl_pkg
`default_nettype wire

// File: rtl/bin_to_7seg.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_7seg
//  Description : Hex digit to 7-segment decoder, active-high segments,
//                seg[6:0] = {g,f,e,d,c,b,a}.
//  Revision    : 1.0  initial release
// ============================================================================
module bin_to_7seg (
    input  logic [3:0] bin,
    output logic [6:0] seg
);

    // Pure lookup of the segment pattern for each hex digit
    always_comb begin
        seg = 7'h00;
        case (bin)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

endmodule : bin_to_7seg
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Free-running divider that emits a one-cycle tick every
//                TICK_DIV enabled cycles. Held at zero while disabled or
//                restarting, so every enabled stretch starts a full period.
//  Revision    : 1.0  initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 50000000,
    parameter int DIV_W    = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam logic [DIV_W-1:0] C_TERM = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] div_q;

    // Next divider value: count while enabled, otherwise park at zero
    always_comb begin
        div_d = '0;
        if (en && !restart) begin
            div_d = (div_q == C_TERM) ? '0 : div_q + DIV_W'(1);
        end
    end

    // Divider register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = en & (div_q == C_TERM);

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/mod_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mod_counter_ctrl
//  Description : Run/pause/single-step controller for a modulo-N display
//                counter. Owns the tick prescaler, decodes button edges,
//                applies clear/load/stop/start/step in fixed priority and
//                drives count, wrap, status and the 7-segment pattern.
//  Revision    : 1.0  initial release
// ============================================================================
module mod_counter_ctrl
    import mod_ctrl_pkg::*;
#(
    parameter int MODULUS  = DEF_MODULUS,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int DIV_W    = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_btn,
    input  logic             stop_btn,
    input  logic             step_btn,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             running,
    output logic             load_err,
    output logic [1:0]       state_dbg,
    output logic [6:0]       seg
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MODULUS - 1);

    // Registered state
    logic [1:0]       state_d,     state_q;
    logic [CNT_W-1:0] count_d,     count_q;
    logic             wrap_d,      wrap_q;
    logic             load_err_d,  load_err_q;
    logic             running_d,   running_q;
    logic             start_btn_d, start_btn_q;
    logic             stop_btn_d,  stop_btn_q;
    logic             step_btn_d,  step_btn_q;

    // Combinational helpers
    logic w_start_rise;
    logic w_stop_rise;
    logic w_step_rise;
    logic w_tick;
    logic w_advance;
    logic w_load_ok;
    logic w_presc_en;
    logic w_presc_restart;

    // Button edge detection; a held button yields a single rise
    always_comb begin
        start_btn_d  = start_btn;
        stop_btn_d   = stop_btn;
        step_btn_d   = step_btn;
        w_start_rise = start_btn & ~start_btn_q;
        w_stop_rise  = stop_btn  & ~stop_btn_q;
        w_step_rise  = step_btn  & ~step_btn_q;
        w_load_ok    = (load_val <= C_CNT_MAX);
    end

    // Control priority, FSM transitions and count update
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        w_advance  = 1'b0;

        if (clear) begin
            // Clear wins over everything but reset; a coincident tick is lost
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    // Load and step are not events while running
                    w_advance = w_tick;
                    if (w_stop_rise) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_IDLE, ST_PAUSE: begin
                    if (load) begin
                        if (w_load_ok) begin
                            count_d = load_val;
                            state_d = ST_PAUSE;
                        end else begin
                            load_err_d = 1'b1;
                        end
                    end else if (w_stop_rise) begin
                        // Already stopped; the stop still masks start/step
                        state_d = state_q;
                    end else if (w_start_rise) begin
                        state_d = ST_RUN;
                    end else if (w_step_rise) begin
                        w_advance = 1'b1;
                        state_d   = ST_PAUSE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (w_advance) begin
                if (count_q == C_CNT_MAX) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
        end

        running_d = (state_d == ST_RUN);
    end

    // Prescaler runs only while staying in RUN; entry and exit park it at zero
    always_comb begin
        w_presc_en      = (state_q == ST_RUN);
        w_presc_restart = (state_d != ST_RUN);
    end

    // State, count and pulse registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            wrap_q      <= 1'b0;
            load_err_q  <= 1'b0;
            running_q   <= 1'b0;
            start_btn_q <= 1'b0;
            stop_btn_q  <= 1'b0;
            step_btn_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wrap_q      <= wrap_d;
            load_err_q  <= load_err_d;
            running_q   <= running_d;
            start_btn_q <= start_btn_d;
            stop_btn_q  <= stop_btn_d;
            step_btn_q  <= step_btn_d;
        end
    end

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_tick_prescaler (
        .clk     (clk),
        .reset   (reset),
        .en      (w_presc_en),
        .restart (w_presc_restart),
        .tick    (w_tick)
    );

    bin_to_7seg u_bin_to_7seg (
        .bin (4'(count_q)),
        .seg (seg)
    );

    assign count     = count_q;
    assign wrap      = wrap_q;
    assign running   = running_q;
    assign load_err  = load_err_q;
    assign state_dbg = state_q;

endmodule : mod_counter_ctrl
`default_nettype wire

// File: tb/tb_mod_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_counter_ctrl
//  Description : Self-checking bench for mod_counter_ctrl with a behavioural
//                reference model, directed scenarios and random stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mod_counter_ctrl;

    localparam int MOD = 13;
    localparam int TD  = 4;

    logic       clk = 1'b0;
    logic       reset, start_btn, stop_btn, step_btn, clear, load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       wrap, running, load_err;
    logic [1:0] state_dbg;
    logic [6:0] seg;

    int n_checks = 0;
    int n_errors = 0;
    int n_wraps  = 0;

    // Reference model state (0 idle, 1 run, 2 pause)
    int m_state = 0;
    int m_count = 0;
    int m_age   = 0;   // cycles spent continuously in run since entry
    bit m_wrap  = 0;
    bit m_lerr  = 0;
    bit p_start = 0, p_stop = 0, p_step = 0;

    always #5 clk = ~clk;

    mod_counter_ctrl #(
        .MODULUS  (MOD),
        .CNT_W    (4),
        .TICK_DIV (TD),
        .DIV_W    (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_btn (start_btn),
        .stop_btn  (stop_btn),
        .step_btn  (step_btn),
        .clear     (clear),
        .load      (load),
        .load_val  (load_val),
        .count     (count),
        .wrap      (wrap),
        .running   (running),
        .load_err  (load_err),
        .state_dbg (state_dbg),
        .seg       (seg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int v);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tbl[v % 16];
    endfunction

    // One clock edge of the specified behaviour, using the inputs seen at that edge
    task automatic model_step();
        bit rs, rp, rt, adv, tick;
        int nxt;
        rs = start_btn && !p_start;
        rp = stop_btn  && !p_stop;
        rt = step_btn  && !p_step;
        m_wrap = 0;
        m_lerr = 0;
        if (reset) begin
            m_state = 0; m_count = 0; m_age = 0;
            p_start = 0; p_stop = 0; p_step = 0;
            return;
        end
        p_start = start_btn; p_stop = stop_btn; p_step = step_btn;
        tick = (m_state == 1) && (m_age % TD == TD - 1);
        if (clear) begin
            m_state = 0; m_count = 0; m_age = 0;
            return;
        end
        nxt = m_state;
        adv = 0;
        if (m_state == 1) begin
            adv = tick;
            if (rp) nxt = 2;
        end else if (load) begin
            if (load_val < MOD) begin
                m_count = load_val;
                nxt = 2;
            end else begin
                m_lerr = 1;
            end
        end else if (rp) begin
            nxt = m_state;
        end else if (rs) begin
            nxt = 1;
        end else if (rt) begin
            adv = 1;
            nxt = 2;
        end
        if (adv) begin
            if (m_count == MOD - 1) begin
                m_count = 0;
                m_wrap = 1;
            end else begin
                m_count = m_count + 1;
            end
        end
        m_age = (m_state == 1 && nxt == 1) ? m_age + 1 : 0;
        m_state = nxt;
    endtask

    task automatic cycle_check();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (wrap === 1'b1) n_wraps++;
        chk("count",     32'(count),     32'(m_count));
        chk("wrap",      32'(wrap),      32'(m_wrap));
        chk("load_err",  32'(load_err),  32'(m_lerr));
        chk("running",   32'(running),   32'(m_state == 1));
        chk("state_dbg", 32'(state_dbg), 32'(m_state));
        chk("seg",       32'(seg),       32'(seg_of(m_count)));
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) cycle_check();
    endtask

    // 0 start, 1 stop, 2 step: one cycle high, one cycle low
    task automatic press(input int b);
        case (b)
            0: start_btn = 1'b1;
            1: stop_btn  = 1'b1;
            default: step_btn = 1'b1;
        endcase
        cycle_check();
        start_btn = 1'b0; stop_btn = 1'b0; step_btn = 1'b0;
        cycle_check();
    endtask

    initial begin
        int w0, n, c0;
        reset = 1'b1; start_btn = 1'b0; stop_btn = 1'b0; step_btn = 1'b0;
        clear = 1'b0; load = 1'b0; load_val = 4'd0;

        // Reset and idle
        run_n(2);
        reset = 1'b0;
        w0 = n_wraps;
        run_n(20);
        chk("idle_count", 32'(count), 32'd0);
        chk("idle_seg", 32'(seg), 32'h3F);
        chk("idle_no_wrap", 32'(n_wraps - w0), 32'd0);

        // Full run: 61 cycles in RUN -> 15 ticks from 0 -> one wrap, ends at 2
        w0 = n_wraps;
        press(0);
        run_n(60);
        chk("run_wraps", 32'(n_wraps - w0), 32'd1);
        chk("run_end_count", 32'(count), 32'd2);

        // Held buttons, then stepping across the wrap from 11
        start_btn = 1'b1; run_n(10); start_btn = 1'b0;
        stop_btn = 1'b1;  run_n(10); stop_btn = 1'b0;
        run_n(1);
        chk("held_stop_pause", 32'(state_dbg), 32'd2);
        load = 1'b1; load_val = 4'd11; cycle_check(); load = 1'b0;
        w0 = n_wraps;
        press(2); press(2); press(2);
        chk("step_count", 32'(count), 32'd1);
        chk("step_wraps", 32'(n_wraps - w0), 32'd1);

        // Pause two cycles after a tick, then resume with a full period
        press(0);
        c0 = count; n = 0;
        while (count == c0 && n < 20) begin cycle_check(); n++; end
        if (n >= 20) chk("timeout_tick", 32'd0, 32'd1);
        run_n(1);
        press(1);
        run_n(5);
        start_btn = 1'b1; c0 = count; cycle_check(); start_btn = 1'b0;
        n = 0;
        while (count == c0 && n < 20) begin cycle_check(); n++; end
        chk("resume_latency", 32'(n), 32'd4);

        // Loads in PAUSE and during RUN
        press(1);
        load = 1'b1; load_val = 4'd9;  cycle_check();
        chk("load9", 32'(count), 32'd9);
        load_val = 4'd13; cycle_check();
        chk("load13_err", 32'(load_err), 32'd1);
        chk("load13_count", 32'(count), 32'd9);
        load = 1'b0; cycle_check();
        press(0);
        load = 1'b1; load_val = 4'd3; run_n(6); load = 1'b0;
        chk("load_in_run_state", 32'(state_dbg), 32'd1);

        // Simultaneous start and stop in PAUSE
        press(1);
        start_btn = 1'b1; stop_btn = 1'b1; cycle_check();
        start_btn = 1'b0; stop_btn = 1'b0; cycle_check();
        chk("start_stop_pause", 32'(state_dbg), 32'd2);

        // Clear on a tick cycle
        press(0);
        n = 0;
        while (!(m_state == 1 && m_age % TD == TD - 1) && n < 20) begin cycle_check(); n++; end
        if (n >= 20) chk("timeout_clear", 32'd0, 32'd1);
        clear = 1'b1; cycle_check(); clear = 1'b0;
        chk("clear_count", 32'(count), 32'd0);
        chk("clear_state", 32'(state_dbg), 32'd0);
        chk("clear_wrap", 32'(wrap), 32'd0);

        // Reset mid-run at count 7
        press(0);
        n = 0;
        while (m_count != 7 && n < 200) begin cycle_check(); n++; end
        if (n >= 200) chk("timeout_reset", 32'd0, 32'd1);
        reset = 1'b1; cycle_check(); reset = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom % 300) == 0;
            clear     = ($urandom % 80) == 0;
            load      = ($urandom % 30) == 0;
            load_val  = 4'($urandom % 16);
            if ($urandom % 6 == 0) start_btn = ~start_btn;
            if ($urandom % 8 == 0) stop_btn  = ~stop_btn;
            if ($urandom % 5 == 0) step_btn  = ~step_btn;
            cycle_check();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mod_counter_ctrl
`default_nettype wire
